// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding valid/ready read per instruction, held for the core until consumed.
// Optional IFU_ALIGN_CHECK_EN: misaligned pc faults locally without touching memory.
module ifu #(
  parameter int unsigned          ADDR_W = 32,
  parameter int unsigned          INST_W = 32,
  parameter logic [INST_W-1:0]    NOP    = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  input  logic              flush,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic              inst_err,
  input  logic              inst_ready,
  output logic              imem_arvalid,
  output logic [ADDR_W-1:0] imem_araddr,
  input  logic              imem_arready,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic [1:0]        imem_rresp,
  output logic              imem_rready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AR   = 2'd1;
  localparam logic [1:0] R    = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0] state;
  logic       drop;

  // Handshake outputs are registered and updated on the same edge as the state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      drop         <= 1'b0;
      imem_arvalid <= 1'b0;
      imem_araddr  <= '0;
      imem_rready  <= 1'b0;
      inst_valid   <= 1'b0;
      inst         <= NOP;
      inst_pc      <= '0;
      inst_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_valid && !flush) begin
`ifdef IFU_ALIGN_CHECK_EN
            if (pc[1:0] != 2'b00) begin
              inst       <= NOP;
              inst_err   <= 1'b1;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end else begin
              imem_araddr  <= {pc[ADDR_W-1:2], 2'b00};
              inst_pc      <= pc;
              imem_arvalid <= 1'b1;
              state        <= AR;
            end
`else
            imem_araddr  <= {pc[ADDR_W-1:2], 2'b00};
            inst_pc      <= pc;
            imem_arvalid <= 1'b1;
            state        <= AR;
`endif
          end
        end
        AR: begin
          // The request stays up until accepted; a flush only marks its data for discard.
          if (flush) drop <= 1'b1;
          if (imem_arready) begin
            imem_arvalid <= 1'b0;
            imem_rready  <= 1'b1;
            state        <= R;
          end
        end
        R: begin
          if (imem_rvalid) begin
            imem_rready <= 1'b0;
            if (drop || flush) begin
              drop  <= 1'b0;
              state <= IDLE;
            end else begin
              inst       <= imem_rdata;
              inst_err   <= (imem_rresp != 2'b00);
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (flush || inst_ready) begin
            inst_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for ifu; the bench drives the memory handshake cycle by cycle.
module tb_ifu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_err;
  logic        inst_ready;
  logic        imem_arvalid;
  logic [31:0] imem_araddr;
  logic        imem_arready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;
  logic        imem_rready;

  int passed = 0;
  int total  = 0;

  ifu #(.ADDR_W(32), .INST_W(32), .NOP(32'h00000013)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .flush(flush),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_err(inst_err),
    .inst_ready(inst_ready), .imem_arvalid(imem_arvalid), .imem_araddr(imem_araddr),
    .imem_arready(imem_arready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .imem_rresp(imem_rresp), .imem_rready(imem_rready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; pc = '0; pc_valid = 1'b0; flush = 1'b0; inst_ready = 1'b0;
    imem_arready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; imem_rresp = '0;
    tick(); tick();
    chk("rst_arvalid", 32'(imem_arvalid), 32'd0);
    chk("rst_araddr", imem_araddr, 32'h0);
    chk("rst_rready", 32'(imem_rready), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h00000013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_err", 32'(inst_err), 32'd0);

    // Reset asserted while waiting in AR
    rst = 1'b1; pc = 32'h10000010; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    chk("ar_arvalid", 32'(imem_arvalid), 32'd1);
    chk("ar_araddr", imem_araddr, 32'h10000010);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_arvalid", 32'(imem_arvalid), 32'd0);
    chk("midrst_araddr", imem_araddr, 32'h0);
    chk("midrst_inst", inst, 32'h00000013);
    chk("midrst_inst_pc", inst_pc, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Zero-wait fetch: pc_valid at edge N, data captured at N+2
    pc = 32'h80000000; pc_valid = 1'b1; imem_arready = 1'b1;
    tick();
    pc_valid = 1'b0;
    chk("zw_arvalid", 32'(imem_arvalid), 32'd1);
    chk("zw_n_inst_valid", 32'(inst_valid), 32'd0);
    tick();
    imem_arready = 1'b0;
    chk("zw_rready", 32'(imem_rready), 32'd1);
    chk("zw_arvalid_low", 32'(imem_arvalid), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h00100093;
    tick();
    imem_rvalid = 1'b0;
    chk("zw_inst_valid", 32'(inst_valid), 32'd1);
    chk("zw_inst", inst, 32'h00100093);
    chk("zw_inst_pc", inst_pc, 32'h80000000);
    chk("zw_inst_err", 32'(inst_err), 32'd0);
    chk("zw_rready_low", 32'(imem_rready), 32'd0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("zw_consumed", 32'(inst_valid), 32'd0);

    // Backpressure on every handshake
    pc = 32'h80000008; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_araddr", imem_araddr, 32'h80000008);
      chk("bp_arvalid", 32'(imem_arvalid), 32'd1);
      tick();
    end
    imem_arready = 1'b1;
    chk("bp_araddr_acc", imem_araddr, 32'h80000008);
    tick();
    imem_arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_rready", 32'(imem_rready), 32'd1);
      chk("bp_r_inst_valid", 32'(inst_valid), 32'd0);
      tick();
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h00200113;
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_valid", 32'(inst_valid), 32'd1);
      chk("bp_hold_inst", inst, 32'h00200113);
      chk("bp_hold_pc", inst_pc, 32'h80000008);
      tick();
    end
    inst_ready = 1'b1;
    chk("bp_hold_last", 32'(inst_valid), 32'd1);
    tick();
    inst_ready = 1'b0;
    chk("bp_done", 32'(inst_valid), 32'd0);
    tick();
    chk("bp_single", 32'(inst_valid), 32'd0);
    chk("bp_idle_arvalid", 32'(imem_arvalid), 32'd0);

    // Flush coinciding with rvalid drops the data
    pc = 32'h80000000; pc_valid = 1'b1; imem_arready = 1'b1;
    tick();
    pc_valid = 1'b0;
    tick();
    imem_arready = 1'b0;
    flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    flush = 1'b0; imem_rvalid = 1'b0;
    chk("fr_inst_valid", 32'(inst_valid), 32'd0);
    chk("fr_rready", 32'(imem_rready), 32'd0);
    chk("fr_inst_kept", inst, 32'h00200113);
    tick();
    chk("fr_idle_valid", 32'(inst_valid), 32'd0);
    chk("fr_idle_arvalid", 32'(imem_arvalid), 32'd0);
    pc = 32'h80000004; pc_valid = 1'b1; imem_arready = 1'b1;
    tick();
    pc_valid = 1'b0;
    chk("fr_next_araddr", imem_araddr, 32'h80000004);
    tick();
    imem_arready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h00308193;
    tick();
    imem_rvalid = 1'b0;
    chk("fr_next_valid", 32'(inst_valid), 32'd1);
    chk("fr_next_inst", inst, 32'h00308193);
    chk("fr_next_pc", inst_pc, 32'h80000004);

    // Flush together with inst_ready in HOLD: flush wins
    flush = 1'b1; inst_ready = 1'b1;
    tick();
    flush = 1'b0; inst_ready = 1'b0;
    chk("fh_valid_drop", 32'(inst_valid), 32'd0);
    pc = 32'h80000100; pc_valid = 1'b1; imem_arready = 1'b1;
    tick();
    pc_valid = 1'b0;
    tick();
    imem_arready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h00408213;
    tick();
    imem_rvalid = 1'b0;
    chk("fh_new_valid", 32'(inst_valid), 32'd1);
    chk("fh_new_pc", inst_pc, 32'h80000100);
    chk("fh_new_inst", inst, 32'h00408213);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // Flush while in AR: request stays up, data later discarded
    pc = 32'h80000020; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fa_arvalid_held", 32'(imem_arvalid), 32'd1);
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h11111111;
    tick();
    imem_rvalid = 1'b0;
    chk("fa_dropped", 32'(inst_valid), 32'd0);
    chk("fa_inst_kept", inst, 32'h00408213);

    // Access fault response
    pc = 32'h80000200; pc_valid = 1'b1; imem_arready = 1'b1;
    tick();
    pc_valid = 1'b0;
    tick();
    imem_arready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0; imem_rresp = 2'b10;
    tick();
    imem_rvalid = 1'b0; imem_rresp = 2'b00;
    chk("fault_valid", 32'(inst_valid), 32'd1);
    chk("fault_err", 32'(inst_err), 32'd1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // Misaligned pc
    pc = 32'h80000002; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
    chk("mis_arvalid", 32'(imem_arvalid), 32'd0);
    chk("mis_valid", 32'(inst_valid), 32'd1);
    chk("mis_err", 32'(inst_err), 32'd1);
    chk("mis_inst", inst, 32'h00000013);
    chk("mis_pc", inst_pc, 32'h80000002);
`else
    chk("mis_arvalid", 32'(imem_arvalid), 32'd1);
    chk("mis_araddr", imem_araddr, 32'h80000000);
    chk("mis_pc", inst_pc, 32'h80000002);
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h00508293;
    tick();
    imem_rvalid = 1'b0;
    chk("mis_valid", 32'(inst_valid), 32'd1);
    chk("mis_err", 32'(inst_err), 32'd0);
`endif
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("end_idle", 32'(inst_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit directly upstream of the single-cycle core. Takes the fetch address from the core's PC register and issues a read on a valid/ready instruction-memory port. Captures the returned word and holds it as `inst` with a valid/ready handshake, so the core advances only on a delivered instruction. Supports flush on redirect (branch/jump target) so stale fetches are never delivered.

## Interface
- `ADDR_W`, 32, fetch address width
- `INST_W`, 32, instruction width
- `NOP`, 32'h00000013, value driven on `inst` out of reset
---
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-low (asserted when 0)
- `pc`  in  ADDR_W  fetch address from core PC register
- `pc_valid`  in  1  core requests instruction at `pc`
- `flush`  in  1  redirect: discard in-flight/held fetch
- `inst`  out  INST_W  fetched instruction (feeds core `cmd`)
- `inst_pc`  out  ADDR_W  address `inst` was fetched from
- `inst_valid`  out  1  `inst` valid
- `inst_err`  out  1  fetch fault for `inst` (valid only with `inst_valid`)
- `inst_ready`  in  1  core consumes `inst` this cycle
- `imem_arvalid`  out  1  read request valid
- `imem_araddr`  out  ADDR_W  read address
- `imem_arready`  in  1  memory accepts request
- `imem_rvalid`  in  1  read data valid
- `imem_rdata`  in  INST_W  read data
- `imem_rresp`  in  2  response; nonzero = access fault
- `imem_rready`  out  1  IFU accepts read data

## Operation
- Reset values: `imem_arvalid`=0, `imem_araddr`=0, `imem_rready`=0, `inst_valid`=0, `inst`=`NOP`, `inst_pc`=0, `inst_err`=0; state IDLE, drop flag 0.
- FSM states: IDLE, AR, R, HOLD.
- IDLE: on edge with `pc_valid`=1 and `flush`=0, latch `pc` into `imem_araddr` and `inst_pc`, go AR. Otherwise stay.
- AR: `imem_arvalid`=1, address stable. On edge with `imem_arready`=1, go R. `imem_arvalid` is never dropped before acceptance, even on flush.
- R: `imem_rready`=1. On edge with `imem_rvalid`=1: if drop flag set, discard, clear drop, go IDLE; else capture `imem_rdata` into `inst`, `inst_err`=(`imem_rresp`!=0), go HOLD.
- HOLD: `inst_valid`=1; `inst`, `inst_pc`, `inst_err` stable. On edge with `inst_ready`=1, go IDLE.
- Flush: in IDLE, blocks the sample that cycle. In AR or R, sets drop flag; the outstanding transaction completes and its data is discarded. In HOLD, deassert `inst_valid` and go IDLE. A flush coinciding with `inst_ready` in HOLD wins: the instruction counts as not consumed. A flush coinciding with `imem_rvalid` in R drops that data.
- Exactly one outstanding memory transaction at any time.
- `inst` retains its last captured value outside HOLD. The core must qualify it with `inst_valid`.
- Reset asserted mid-transaction returns everything to reset values immediately. Memory-side completion of an abandoned transaction is the memory's responsibility.

## Timing
- Zero-wait memory (`arready`=1, `rvalid` the cycle after acceptance): `pc_valid` sampled at edge N, `arvalid` high in cycle N..N+1, data captured at edge N+2, `inst_valid` high from edge N+2.
- Each wait cycle on `arready` or `rvalid` adds one cycle.
- Throughput: at most one instruction per 4 cycles (IDLE, AR, R, HOLD).
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- `IFU_ALIGN_CHECK_EN` defined: in IDLE, `pc[1:0]`!=0 skips memory and goes directly to HOLD with `inst_err`=1, `inst`=`NOP`, `inst_pc`=`pc`.
- Undefined: no check. `imem_araddr` is driven with `pc[1:0]` forced to 0, and `inst_pc` keeps the unmodified `pc`.

## Test plan
- Reset: hold `rst`=0 mid-AR → all outputs at reset values and `inst`=0x00000013. Release, then `pc`=0x80000000 with zero-wait memory returning 0x00100093 → `inst_valid` at edge N+2, `inst`=0x00100093, `inst_pc`=0x80000000.
- Backpressure: `arready` low 3 cycles, `rvalid` low 2 cycles, `inst_ready` low 4 cycles → `araddr` and `inst` remain stable throughout, and exactly one instruction is delivered.
- Flush in R at the same edge as `rvalid` with data 0xDEADBEEF → no `inst_valid`, FSM returns to IDLE. Next fetch of 0x80000004 delivers the correct word.
- Flush and `inst_ready` simultaneously in HOLD → `inst_valid` drops, and the next delivered `inst_pc` is the new `pc`.
- Fault: `rresp`=2'b10 → `inst_valid`=1, `inst_err`=1.
- `pc`=0x80000002 with `IFU_ALIGN_CHECK_EN` → no `arvalid`, `inst_err`=1 after one edge. Without the macro → `araddr`=0x80000000, `inst_err`=0.
